// File: rtl/stim_lane_tx.sv
// stim_lane_tx: drives a reset pulse and a selectable per-lane bit pattern into
// downstream lane flops, then parks in DONE until the next run is requested.
// Optional return checker is compiled only when STIM_LANE_TX_CHECK_EN is defined.
module stim_lane_tx #(
    parameter int LANES      = 1,
    parameter int RST_CYCLES = 9,
    parameter int RUN_CYCLES = 80
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       mode,
    output logic             rst_out,
    output logic [LANES-1:0] u_out,
    input  logic [LANES-1:0] w_in,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [7:0]       err_cnt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RST   = 2'd1,
        DRIVE = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [15:0] RST_LAST  = 16'(RST_CYCLES - 1);
    localparam logic [15:0] RUN_LAST  = 16'(RUN_CYCLES - 1);
    localparam logic [3:0]  LANE_LAST = 4'(LANES - 1);

    state_t           state, state_next;
    logic [15:0]      cnt, cnt_next;
    logic [3:0]       lane_idx, lane_idx_next;
    logic [1:0]       mode_q, mode_next;
    logic [LANES-1:0] pattern;

    // Next-state, phase counter and lane-index counter (lane index tracks cnt mod LANES)
    always_comb begin
        state_next    = state;
        cnt_next      = cnt;
        lane_idx_next = lane_idx;
        mode_next     = mode_q;
        case (state)
            IDLE, DONE: begin
                if (start) begin
                    state_next    = RST;
                    mode_next     = mode;
                    cnt_next      = 16'd0;
                    lane_idx_next = 4'd0;
                end
            end
            RST: begin
                if (cnt == RST_LAST) begin
                    state_next    = DRIVE;
                    cnt_next      = 16'd0;
                    lane_idx_next = 4'd0;
                end else begin
                    cnt_next = cnt + 16'd1;
                end
            end
            DRIVE: begin
                if (cnt == RUN_LAST) begin
                    state_next    = DONE;
                    cnt_next      = 16'd0;
                    lane_idx_next = 4'd0;
                end else begin
                    cnt_next      = cnt + 16'd1;
                    lane_idx_next = (lane_idx == LANE_LAST) ? 4'd0 : lane_idx + 4'd1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Per-lane pattern for the upcoming cycle, so u_out can be registered
    for (genvar i = 0; i < LANES; i++) begin : g_lane
        assign pattern[i] = (mode_next == 2'd0) ? 1'b1 :
                            (mode_next == 2'd1) ? (lane_idx_next == 4'(i)) :
                            (mode_next == 2'd2) ? cnt_next[i] :
                                                  cnt_next[0];
    end

    // State register and counters
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= 16'd0;
            lane_idx <= 4'd0;
            mode_q   <= 2'd0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            lane_idx <= lane_idx_next;
            mode_q   <= mode_next;
        end
    end

    // Registered outputs, decoded from the next state so they line up with the state
    always_ff @(posedge clk) begin
        if (reset) begin
            rst_out <= 1'b0;
            u_out   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            rst_out <= (state_next == RST);
            u_out   <= (state_next == DRIVE) ? pattern : '0;
            busy    <= (state_next == RST) || (state_next == DRIVE);
            done    <= (state_next == DONE);
        end
    end

`ifdef STIM_LANE_TX_CHECK_EN
    logic [LANES-1:0] exp_u;
    logic             exp_valid;
    logic             start_ok;
    logic             mismatch;

    assign start_ok = start && ((state == IDLE) || (state == DONE));
    assign mismatch = exp_valid && (w_in != exp_u);

    // Return checker: downstream echoes u_out one cycle later; a new run clears the tally
    always_ff @(posedge clk) begin
        if (reset) begin
            exp_u     <= '0;
            exp_valid <= 1'b0;
            err       <= 1'b0;
            err_cnt   <= 8'd0;
        end else begin
            exp_u     <= u_out;
            exp_valid <= (state == DRIVE);
            if (start_ok) begin
                err     <= 1'b0;
                err_cnt <= 8'd0;
            end else if (mismatch) begin
                err <= 1'b1;
                if (err_cnt != 8'hFF) begin
                    err_cnt <= err_cnt + 8'd1;
                end
            end
        end
    end
`else
    logic w_in_unused;

    assign w_in_unused = ^w_in;
    assign err         = 1'b0;
    assign err_cnt     = 8'd0;
`endif

endmodule

// File: tb/tb_stim_lane_tx.sv
// tb_stim_lane_tx: two instances (1 lane / default lengths, 4 lanes / long run)
// checked each cycle against a run-trace scoreboard built from the pattern rules.
module tb_stim_lane_tx;

    localparam int A_L = 1;
    localparam int A_R = 9;
    localparam int A_N = 80;
    localparam int B_L = 4;
    localparam int B_R = 3;
    localparam int B_N = 300;

    typedef struct packed {
        logic        rst;
        logic [15:0] u;
        logic        busy;
        logic        done;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic           reset;
    logic           start_a, start_b;
    logic [1:0]     mode_a, mode_b;
    logic           rst_out_a, rst_out_b;
    logic [A_L-1:0] u_out_a, w_in_a, echo_a, w_rand_a;
    logic [B_L-1:0] u_out_b, w_in_b, echo_b, w_rand_b;
    logic           busy_a, busy_b, done_a, done_b, err_a, err_b;
    logic [7:0]     err_cnt_a, err_cnt_b;
    logic [1:0]     wsel_a, wsel_b;

    int   n_checks = 0;
    int   n_fail   = 0;
    bit   armed    = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t rest_v [2];
    bit   prev_drive [2];
    logic [15:0] prev_u [2];
    int   mcnt [2];
    bit   merr [2];

    stim_lane_tx #(.LANES(A_L), .RST_CYCLES(A_R), .RUN_CYCLES(A_N)) u_dut_a (
        .clk(clk), .reset(reset), .start(start_a), .mode(mode_a),
        .rst_out(rst_out_a), .u_out(u_out_a), .w_in(w_in_a),
        .busy(busy_a), .done(done_a), .err(err_a), .err_cnt(err_cnt_a)
    );

    stim_lane_tx #(.LANES(B_L), .RST_CYCLES(B_R), .RUN_CYCLES(B_N)) u_dut_b (
        .clk(clk), .reset(reset), .start(start_b), .mode(mode_b),
        .rst_out(rst_out_b), .u_out(u_out_b), .w_in(w_in_b),
        .busy(busy_b), .done(done_b), .err(err_b), .err_cnt(err_cnt_b)
    );

    // Downstream lane flops: return path is u_out delayed by one register
    always @(posedge clk) begin
        echo_a <= u_out_a;
        echo_b <= u_out_b;
    end

    assign w_in_a = (wsel_a == 2'd0) ? echo_a : (wsel_a == 2'd1) ? '0 : w_rand_a;
    assign w_in_b = (wsel_b == 2'd0) ? echo_b : (wsel_b == 2'd1) ? '0 : w_rand_b;

    // Expected lane pattern for drive cycle j of a run
    function automatic logic [15:0] pat(input int lanes, input int m, input int j);
        logic [15:0] all;
        all = 16'((1 << lanes) - 1);
        case (m)
            0:       return all;
            1:       return 16'(1 << (j % lanes));
            2:       return 16'(j) & all;
            default: return ((j % 2) == 1) ? all : 16'd0;
        endcase
    endfunction

    // Queue the full output trace of an accepted run
    task automatic pushRun(input int k, input int m);
        exp_t e;
        int   r, n, l;
        r = (k == 0) ? A_R : B_R;
        n = (k == 0) ? A_N : B_N;
        l = (k == 0) ? A_L : B_L;
        for (int c = 0; c < r; c++) begin
            e.rst = 1'b1; e.u = 16'd0; e.busy = 1'b1; e.done = 1'b0;
            if (k == 0) qa.push_back(e); else qb.push_back(e);
        end
        for (int j = 0; j < n; j++) begin
            e.rst = 1'b0; e.u = pat(l, m, j); e.busy = 1'b1; e.done = 1'b0;
            if (k == 0) qa.push_back(e); else qb.push_back(e);
        end
        rest_v[k] = '{rst: 1'b0, u: 16'd0, busy: 1'b0, done: 1'b1};
    endtask

    // Monitor step: pop expectation, compare, then advance the model with sampled inputs
    task automatic checkOutput(input int k, input bit do_cmp);
        exp_t        e, act;
        bit          from_q;
        logic [15:0] w;
        logic [7:0]  a_cnt, x_cnt;
        logic        a_err, x_err, st, rs;
        logic [1:0]  md;
        rs = reset;
        if (k == 0) begin
            act.rst = rst_out_a; act.u = 16'(u_out_a); act.busy = busy_a; act.done = done_a;
            a_err = err_a; a_cnt = err_cnt_a; w = 16'(w_in_a); st = start_a; md = mode_a;
        end else begin
            act.rst = rst_out_b; act.u = 16'(u_out_b); act.busy = busy_b; act.done = done_b;
            a_err = err_b; a_cnt = err_cnt_b; w = 16'(w_in_b); st = start_b; md = mode_b;
        end
        if (k == 0 && qa.size() > 0) begin
            e = qa.pop_front(); from_q = 1;
        end else if (k == 1 && qb.size() > 0) begin
            e = qb.pop_front(); from_q = 1;
        end else begin
            e = rest_v[k]; from_q = 0;
        end
`ifdef STIM_LANE_TX_CHECK_EN
        x_cnt = 8'(mcnt[k]);
        x_err = merr[k];
`else
        x_cnt = 8'd0;
        x_err = 1'b0;
`endif
        if (do_cmp) begin
            n_checks++;
            if (act !== e) begin
                n_fail++;
                $display("[TB] FAIL inst%0d outputs @%0t: got rst=%b u=%h busy=%b done=%b, want rst=%b u=%h busy=%b done=%b",
                         k, $time, act.rst, act.u, act.busy, act.done, e.rst, e.u, e.busy, e.done);
            end
            n_checks++;
            if (a_err !== x_err || a_cnt !== x_cnt) begin
                n_fail++;
                $display("[TB] FAIL inst%0d err @%0t: got err=%b cnt=%0d, want err=%b cnt=%0d",
                         k, $time, a_err, a_cnt, x_err, x_cnt);
            end
        end
        if (rs) begin
            if (k == 0) qa.delete(); else qb.delete();
            rest_v[k]     = '{rst: 1'b0, u: 16'd0, busy: 1'b0, done: 1'b0};
            prev_drive[k] = 0;
            prev_u[k]     = 16'd0;
            mcnt[k]       = 0;
            merr[k]       = 0;
        end else begin
            if (st && !from_q) begin
                mcnt[k] = 0;
                merr[k] = 0;
                pushRun(k, int'(md));
            end else if (prev_drive[k] && (w !== prev_u[k])) begin
                merr[k] = 1;
                if (mcnt[k] < 255) mcnt[k]++;
            end
            prev_drive[k] = from_q && !e.rst;
            prev_u[k]     = e.u;
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            checkOutput(0, armed);
            checkOutput(1, armed);
            if (reset) armed = 1;
        end
    end

    // Advance one cycle; inputs change just after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        w_rand_a = A_L'($urandom);
        w_rand_b = B_L'($urandom);
    endtask

    task automatic applyStimulus(input int k, input logic [1:0] m, input logic [1:0] wp);
        if (k == 0) begin
            start_a = 1'b1; mode_a = m; wsel_a = wp;
        end else begin
            start_b = 1'b1; mode_b = m; wsel_b = wp;
        end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
    endtask

    task automatic waitDone(input int k, input int budget);
        int n;
        n = 0;
        while (((k == 0) ? done_a : done_b) !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        n_checks++;
        if (n >= budget) begin
            n_fail++;
            $display("[TB] FAIL inst%0d done_timeout: got no done after %0d cycles, want done", k, n);
        end
    endtask

    task automatic checkCount(input string name, input int act, input int want);
        n_checks++;
        if (act != want) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0d, want %0d", name, act, want);
        end
    endtask

    initial begin
        int exp80, exp255;
`ifdef STIM_LANE_TX_CHECK_EN
        exp80  = 80;
        exp255 = 255;
`else
        exp80  = 0;
        exp255 = 0;
`endif
        reset = 1'b1; start_a = 1'b0; start_b = 1'b0; mode_a = 2'd0; mode_b = 2'd0;
        wsel_a = 2'd0; wsel_b = 2'd0; w_rand_a = '0; w_rand_b = '0;
        repeat (3) tick();
        reset = 1'b0;
        repeat (2) tick();

        // Basic runs with echoed return: one lane all-ones, four lanes walking one
        applyStimulus(0, 2'd0, 2'd0);
        waitDone(0, 200);
        applyStimulus(1, 2'd1, 2'd0);
        waitDone(1, 400);
        repeat (2) tick();

        // Stuck-low return: full-run mismatch count and saturation
        applyStimulus(0, 2'd0, 2'd1);
        waitDone(0, 200);
        repeat (2) tick();
        checkCount("stuck_cnt_80", int'(err_cnt_a), exp80);
        applyStimulus(1, 2'd0, 2'd1);
        waitDone(1, 400);
        repeat (2) tick();
        checkCount("stuck_cnt_255", int'(err_cnt_b), exp255);

        // Restart from DONE: toggling mode, random return on B, start while busy ignored
        applyStimulus(0, 2'd3, 2'd0);
        checkCount("done_clear_a", int'(done_a), 0);
        applyStimulus(1, 2'd2, 2'd2);
        repeat (4) tick();
        applyStimulus(0, 2'd1, 2'd0);
        waitDone(0, 200);
        waitDone(1, 400);
        repeat (2) tick();

        // Reset in the middle of DRIVE, with start asserted at the same time
        applyStimulus(0, 2'd1, 2'd2);
        repeat (A_R + 5) tick();
        reset = 1'b1;
        start_a = 1'b1;
        tick();
        reset = 1'b0;
        start_a = 1'b0;
        checkCount("abort_u_out", int'(u_out_a), 0);
        checkCount("abort_busy", int'(busy_a), 0);
        repeat (3) tick();

        // Randomised runs
        for (int i = 0; i < 6; i++) begin
            int k;
            k = $urandom_range(0, 1);
            applyStimulus(k, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 2)));
            waitDone(k, 400);
            repeat (2) tick();
        end

        repeat (3) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
